mem_port_arbiter: RTL and testbench

- Shares the single backing-memory port between two cache_sram-style requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each requester issues a one-cycle rd/wr pulse, then stalls until it sees a one-cycle ACK.
- The arbiter does the following:
  - latches each pulse into a per-port pending slot;
  - grants the slots round-robin;
  - runs a level-held req/ack transaction on the memory bus;
  - returns a registered ACK, plus read data, to the owning requester.
- It also has a timeout so a dead memory cannot hang the pipeline.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one backing-memory port.
// Port 0 is the instruction cache and port 1 is the data cache. Each requester
// pulse is captured into a per-port slot. Slots are granted round-robin and run
// as a level-held req/ack memory transaction. A registered ACK, plus any read
// data, is returned to the requester that owns the slot.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_addr_0,
  input  logic [DW-1:0] i_data_0,
  input  logic          i_rd_0,
  input  logic          i_wr_0,
  output logic [DW-1:0] o_data_0,
  output logic          o_ack_0,
  input  logic [AW-1:0] i_addr_1,
  input  logic [DW-1:0] i_data_1,
  input  logic          i_rd_1,
  input  logic          i_wr_1,
  output logic [DW-1:0] o_data_1,
  output logic          o_ack_1,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_timeout,
  output logic          o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  // The counter only has to reach TIMEOUT-1.
  localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [1:0]    r_pending;
  logic [1:0]    r_isWrite;
  logic [AW-1:0] r_addr  [2];
  logic [DW-1:0] r_wdata [2];
  logic          r_grant;
  logic          r_lastGrant;
  logic [CW-1:0] r_count;
  logic [1:0]    r_ack;
  logic [DW-1:0] r_dataOut [2];
  logic          r_timeout;

  logic [1:0]    w_reqRd;
  logic [1:0]    w_reqWr;
  logic [AW-1:0] w_reqAddr [2];
  logic [DW-1:0] w_reqData [2];
  logic [1:0]    w_freeing;
  logic [1:0]    w_capture;
  logic          w_nextGrant;
  logic          w_timeoutHit;

  assign w_reqRd      = {i_rd_1, i_rd_0};
  assign w_reqWr      = {i_wr_1, i_wr_0};
  assign w_reqAddr[0] = i_addr_0;
  assign w_reqAddr[1] = i_addr_1;
  assign w_reqData[0] = i_data_0;
  assign w_reqData[1] = i_data_1;

  // A slot is released in RESP. A pulse that arrives in that same cycle takes
  // the slot over, so a refill issued in the write-back ACK cycle is not lost.
  assign w_freeing[0] = (r_state == S_RESP) && !r_grant;
  assign w_freeing[1] = (r_state == S_RESP) &&  r_grant;
  assign w_capture    = (w_reqRd | w_reqWr) & (~r_pending | w_freeing);

  // On a tie, the port that did not win last time gets the grant.
  assign w_nextGrant  = (&r_pending) ? ~r_lastGrant : r_pending[1];
  assign w_timeoutHit = (TIMEOUT != 0) && (r_count == TMAX);

  // Per-port pending slots: capture overrides release; when rd and wr are both high, the request is a write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_isWrite <= '0;
      for (int p = 0; p < 2; p++) begin
        r_addr[p]  <= '0;
        r_wdata[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (w_capture[p]) begin
          r_pending[p] <= 1'b1;
          r_isWrite[p] <= w_reqWr[p];
          r_addr[p]    <= w_reqAddr[p];
          r_wdata[p]   <= w_reqData[p];
        end else if (w_freeing[p]) begin
          r_pending[p] <= 1'b0;
        end
      end
    end
  end

  // Grant, memory handshake with timeout, and registered ACK/data/timeout generation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_count     <= '0;
      r_ack       <= '0;
      r_timeout   <= 1'b0;
      r_dataOut[0] <= '0;
      r_dataOut[1] <= '0;
    end else begin
      r_ack     <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|r_pending) begin
            r_grant     <= w_nextGrant;
            r_lastGrant <= w_nextGrant;
            r_count     <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mem_ack) begin
            r_ack[r_grant] <= 1'b1;
            if (!r_isWrite[r_grant]) r_dataOut[r_grant] <= i_mem_rdata;
            r_state <= S_RESP;
          end else if (w_timeoutHit) begin
            r_ack[r_grant] <= 1'b1;
            r_timeout      <= 1'b1;
            if (!r_isWrite[r_grant]) r_dataOut[r_grant] <= '0;
            r_state <= S_RESP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_rd    = (r_state == S_ISSUE) && !r_isWrite[r_grant];
  assign o_mem_wr    = (r_state == S_ISSUE) &&  r_isWrite[r_grant];
  assign o_mem_addr  = (r_state == S_ISSUE) ? r_addr[r_grant]  : '0;
  assign o_mem_wdata = (r_state == S_ISSUE) ? r_wdata[r_grant] : '0;
  assign o_ack_0     = r_ack[0];
  assign o_ack_1     = r_ack[1];
  assign o_data_0    = r_dataOut[0];
  assign o_data_1    = r_dataOut[1];
  assign o_timeout   = r_timeout;
  assign o_busy      = (r_state != S_IDLE) || (|r_pending);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter, run with TIMEOUT=4.
// Contains a small memory responder with programmable wait states and a log of
// accepted memory transactions.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_addr_0 = '0, i_data_0 = '0, i_addr_1 = '0, i_data_1 = '0;
  logic        i_rd_0 = 1'b0, i_wr_0 = 1'b0, i_rd_1 = 1'b0, i_wr_1 = 1'b0;
  logic [31:0] o_data_0, o_data_1, o_mem_addr, o_mem_wdata;
  logic        o_ack_0, o_ack_1, o_mem_rd, o_mem_wr, o_timeout, o_busy;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic        memEnable = 1'b1;
  logic        manualAck = 1'b0;
  int          memWaits  = 0;
  logic [31:0] memRdata  = '0;
  int          waitCnt   = 0;
  int          logCnt    = 0;
  logic [31:0] logAddr [64];
  logic [31:0] logData [64];
  logic        logWr   [64];

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_addr_0(i_addr_0), .i_data_0(i_data_0), .i_rd_0(i_rd_0), .i_wr_0(i_wr_0),
    .o_data_0(o_data_0), .o_ack_0(o_ack_0),
    .i_addr_1(i_addr_1), .i_data_1(i_data_1), .i_rd_1(i_rd_1), .i_wr_1(i_wr_1),
    .o_data_1(o_data_1), .o_ack_1(o_ack_1),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory responder: acks after memWaits wait cycles, or follows manualAck when disabled.
  always @(negedge i_clk) begin
    if (!memEnable) begin
      i_mem_ack = manualAck;
      waitCnt   = 0;
    end else if (o_mem_rd || o_mem_wr) begin
      if (waitCnt >= memWaits) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = memRdata;
        if (logCnt < 64) begin
          logAddr[logCnt] = o_mem_addr;
          logData[logCnt] = o_mem_wdata;
          logWr[logCnt]   = o_mem_wr;
          logCnt++;
        end
        waitCnt = 0;
      end else begin
        i_mem_ack = 1'b0;
        waitCnt++;
      end
    end else begin
      i_mem_ack = 1'b0;
      waitCnt   = 0;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic resetDut();
    i_rd_0 = 0; i_wr_0 = 0; i_rd_1 = 0; i_wr_1 = 0;
    memEnable = 1; manualAck = 0;
    i_rst = 1;
    tick();
    tick();
    i_rst = 0;
  endtask

  task automatic test_reset();
    resetDut();
    checks++;
    if ({o_ack_0, o_ack_1, o_mem_rd, o_mem_wr, o_timeout, o_busy} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=000000",
               {o_ack_0, o_ack_1, o_mem_rd, o_mem_wr, o_timeout, o_busy});
    end
    checks++;
    if ({o_data_0, o_data_1} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_data got=%h exp=0", {o_data_0, o_data_1});
    end
    checks++;
    if ({o_mem_addr, o_mem_wdata} !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_membus got=%h exp=0", {o_mem_addr, o_mem_wdata});
    end
  endtask

  task automatic test_single_read();
    resetDut();
    memWaits = 0; memRdata = 32'hDEAD_BEEF;
    i_addr_0 = 32'h100; i_rd_0 = 1;
    tick();
    i_rd_0 = 0;
    checks++;
    if ({o_busy, o_mem_rd} !== 2'b10) begin
      errors++; $display("[TB] FAIL single_pending got=%b exp=10", {o_busy, o_mem_rd});
    end
    tick();
    checks++;
    if (o_mem_rd !== 1'b1 || o_mem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL single_issue got rd=%b addr=%h exp rd=1 addr=100", o_mem_rd, o_mem_addr);
    end
    tick();
    checks++;
    if ({o_ack_0, o_ack_1, o_mem_rd} !== 3'b100) begin
      errors++; $display("[TB] FAIL single_ack got=%b exp=100", {o_ack_0, o_ack_1, o_mem_rd});
    end
    checks++;
    if (o_data_0 !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL single_data got=%h exp=deadbeef", o_data_0);
    end
    tick();
    checks++;
    if ({o_ack_0, o_busy} !== 2'b00 || o_data_0 !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL single_after got ack=%b busy=%b data=%h exp 0 0 deadbeef", o_ack_0, o_busy, o_data_0);
    end
  endtask

  task automatic test_simultaneous();
    int ack0Cyc, ack1Cyc, base;
    logic [31:0] d0, d1;
    resetDut();
    ack0Cyc = 0; ack1Cyc = 0; d0 = '0; d1 = '1;
    base = logCnt;
    memWaits = 2; memRdata = 32'hA5A5_0040;
    i_addr_0 = 32'h40; i_rd_0 = 1;
    i_addr_1 = 32'h80; i_data_1 = 32'h1234_5678; i_wr_1 = 1;
    tick();
    i_rd_0 = 0; i_wr_1 = 0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (o_ack_0) begin ack0Cyc = c; d0 = o_data_0; end
      if (o_ack_1) begin ack1Cyc = c; d1 = o_data_1; end
    end
    checks++;
    if (ack0Cyc != 5 || ack1Cyc != 10) begin
      errors++; $display("[TB] FAIL simul_timing got ack0=%0d ack1=%0d exp 5 10", ack0Cyc, ack1Cyc);
    end
    checks++;
    if (d0 !== 32'hA5A5_0040 || d1 !== 32'h0) begin
      errors++; $display("[TB] FAIL simul_data got d0=%h d1=%h exp a5a50040 0", d0, d1);
    end
    checks++;
    if (logCnt - base != 2 || logAddr[base] !== 32'h40 || logWr[base] !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_first got n=%0d addr=%h wr=%b exp 2 40 0", logCnt - base, logAddr[base], logWr[base]);
    end
    checks++;
    if (logAddr[base+1] !== 32'h80 || logWr[base+1] !== 1'b1 || logData[base+1] !== 32'h1234_5678) begin
      errors++; $display("[TB] FAIL simul_write got addr=%h wr=%b data=%h exp 80 1 12345678",
                         logAddr[base+1], logWr[base+1], logData[base+1]);
    end
  endtask

  task automatic test_writeback_refill();
    resetDut();
    memWaits = 0; memRdata = 32'h0BAD_F00D;
    i_addr_1 = 32'h200; i_data_1 = 32'h0000_CAFE; i_wr_1 = 1;
    tick();
    i_wr_1 = 0;
    tick();
    checks++;
    if (o_mem_wr !== 1'b1 || o_mem_addr !== 32'h200 || o_mem_wdata !== 32'h0000_CAFE) begin
      errors++; $display("[TB] FAIL wb_issue got wr=%b addr=%h wd=%h exp 1 200 cafe", o_mem_wr, o_mem_addr, o_mem_wdata);
    end
    tick();
    checks++;
    if (o_ack_1 !== 1'b1 || o_data_1 !== 32'h0) begin
      errors++; $display("[TB] FAIL wb_ack got ack=%b data=%h exp 1 0", o_ack_1, o_data_1);
    end
    i_addr_1 = 32'h400; i_rd_1 = 1;
    tick();
    i_rd_1 = 0;
    checks++;
    if ({o_busy, o_ack_1} !== 2'b10) begin
      errors++; $display("[TB] FAIL refill_captured got=%b exp=10", {o_busy, o_ack_1});
    end
    tick();
    checks++;
    if (o_mem_rd !== 1'b1 || o_mem_addr !== 32'h400) begin
      errors++; $display("[TB] FAIL refill_issue got rd=%b addr=%h exp 1 400", o_mem_rd, o_mem_addr);
    end
    tick();
    checks++;
    if (o_ack_1 !== 1'b1 || o_data_1 !== 32'h0BAD_F00D || o_ack_0 !== 1'b0) begin
      errors++; $display("[TB] FAIL refill_ack got ack1=%b data=%h ack0=%b exp 1 0badf00d 0", o_ack_1, o_data_1, o_ack_0);
    end
  endtask

  task automatic test_fairness();
    int n, base;
    logic [5:0] order;
    resetDut();
    n = 0; order = '0;
    base = logCnt;
    memWaits = 0; memRdata = 32'h5555_AAAA;
    i_addr_0 = 32'h1000; i_addr_1 = 32'h2000;
    i_rd_0 = 1; i_rd_1 = 1;
    tick();
    i_rd_0 = 0; i_rd_1 = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      i_rd_0 = 0; i_rd_1 = 0;
      if (o_ack_0 && n < 6) begin order[n] = 1'b0; n++; if (n <= 4) i_rd_0 = 1; end
      if (o_ack_1 && n < 6) begin order[n] = 1'b1; n++; if (n <= 4) i_rd_1 = 1; end
    end
    i_rd_0 = 0; i_rd_1 = 0;
    checks++;
    if (n != 6) begin
      errors++; $display("[TB] FAIL fair_count got=%0d exp=6", n);
    end
    checks++;
    if (order !== 6'b101010) begin
      errors++; $display("[TB] FAIL fair_order got=%b exp=101010 (bit0 first)", order);
    end
    checks++;
    if (logAddr[base] !== 32'h1000 || logAddr[base+1] !== 32'h2000) begin
      errors++; $display("[TB] FAIL fair_addr got %h %h exp 1000 2000", logAddr[base], logAddr[base+1]);
    end
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("[TB] FAIL fair_idle got busy=%b exp 0", o_busy);
    end
  endtask

  task automatic test_timeout();
    int rdCnt;
    logic seen, tmo, ack1;
    logic [31:0] dat;
    resetDut();
    rdCnt = 0; seen = 0; tmo = 0; ack1 = 0; dat = '1;
    memWaits = 0; memRdata = 32'h1111_2222;
    i_addr_0 = 32'h280; i_rd_0 = 1;
    tick();
    i_rd_0 = 0;
    tick(); tick(); tick();
    checks++;
    if (o_data_0 !== 32'h1111_2222) begin
      errors++; $display("[TB] FAIL tmo_preload got=%h exp=11112222", o_data_0);
    end
    memEnable = 0; manualAck = 0;
    i_addr_0 = 32'h300; i_rd_0 = 1;
    tick();
    i_rd_0 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_mem_rd) rdCnt++;
      if (o_ack_0) begin seen = 1; dat = o_data_0; tmo = o_timeout; ack1 = o_ack_1; break; end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL tmo_ack got none exp ack within 20 cycles");
    end
    checks++;
    if (rdCnt != 4) begin
      errors++; $display("[TB] FAIL tmo_rd_cycles got=%0d exp=4", rdCnt);
    end
    checks++;
    if (dat !== 32'h0 || tmo !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("[TB] FAIL tmo_resp got data=%h tmo=%b ack1=%b exp 0 1 0", dat, tmo, ack1);
    end
    tick();
    checks++;
    if ({o_timeout, o_busy, o_ack_0} !== 3'b000) begin
      errors++; $display("[TB] FAIL tmo_after got=%b exp=000", {o_timeout, o_busy, o_ack_0});
    end
    memEnable = 1;
  endtask

  task automatic test_reset_mid_issue();
    logic seen;
    logic [31:0] dat;
    resetDut();
    seen = 0; dat = '0;
    memEnable = 0; manualAck = 0;
    i_addr_0 = 32'h500; i_data_0 = 32'h77; i_wr_0 = 1;
    tick();
    i_wr_0 = 0;
    tick();
    checks++;
    if (o_mem_wr !== 1'b1 || o_mem_wdata !== 32'h77) begin
      errors++; $display("[TB] FAIL rstmid_issue got wr=%b wd=%h exp 1 77", o_mem_wr, o_mem_wdata);
    end
    i_rst = 1;
    tick();
    i_rst = 0;
    checks++;
    if ({o_mem_wr, o_busy, o_ack_0} !== 3'b000) begin
      errors++; $display("[TB] FAIL rstmid_abandon got=%b exp=000", {o_mem_wr, o_busy, o_ack_0});
    end
    manualAck = 1;
    tick();
    manualAck = 0;
    tick();
    checks++;
    if ({o_ack_0, o_ack_1, o_busy, o_timeout} !== 4'b0000) begin
      errors++; $display("[TB] FAIL rstmid_lateack got=%b exp=0000", {o_ack_0, o_ack_1, o_busy, o_timeout});
    end
    memEnable = 1; memWaits = 1; memRdata = 32'h0000_600D;
    i_addr_1 = 32'h600; i_rd_1 = 1;
    tick();
    i_rd_1 = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_ack_1) begin seen = 1; dat = o_data_1; break; end
    end
    checks++;
    if (!seen || dat !== 32'h0000_600D) begin
      errors++; $display("[TB] FAIL rstmid_recover got seen=%b data=%h exp 1 0000600d", seen, dat);
    end
  endtask

  initial begin
    $display("[TB] mem_port_arbiter directed tests start");
    test_reset();
    test_single_read();
    test_simultaneous();
    test_writeback_refill();
    test_fairness();
    test_timeout();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
